// File: rtl/seg7_scan_ctrl_if.sv
// Bus between a display-data source and the seven-segment scan controller.
// The source drives the BCD word and load strobe; the controller drives the display outputs.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd_word;
  logic                    load;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  modport master (
    output bcd_word,
    output load,
    input  bcd_out,
    input  digit_en,
    input  frame_done
  );

  modport slave (
    input  bcd_word,
    input  load,
    output bcd_out,
    output digit_en,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan controller with frame-aligned updates.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 is always shown).
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ?
                        REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t state, state_d;

  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d;
  logic [DW-1:0] pend_q, pend_d;
  logic [DW-1:0] disp_q, disp_d;
  logic          pend_vld, pend_vld_d;

  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fd_q, fd_d;

  logic blank_end;
  logic show_end;
  logic wrap;

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] tail_zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BLANK;
      cnt      <= '0;
      idx      <= '0;
      pend_q   <= '0;
      pend_vld <= 1'b0;
      disp_q   <= '0;
      bcd_q    <= '0;
      en_q     <= '0;
      fd_q     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      pend_q   <= pend_d;
      pend_vld <= pend_vld_d;
      disp_q   <= disp_d;
      bcd_q    <= bcd_d;
      en_q     <= en_d;
      fd_q     <= fd_d;
    end
  end

  always_comb begin
    blank_end = (state == BLANK) && (cnt == BLANK_LAST);
    show_end  = (state == SHOW) && (cnt == SHOW_LAST);
    wrap      = show_end && (idx == IDX_LAST);

    state_d = state;
    cnt_d   = cnt + CW'(1);
    idx_d   = idx;

    unique case (1'b1)
      blank_end: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
      show_end: begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = wrap ? '0 : idx + IW'(1);
      end
      default: ;
    endcase

    pend_d     = pend_q;
    pend_vld_d = pend_vld;
    disp_d     = disp_q;

    // A load landing on the wrap edge bypasses the pending slot
    if (wrap) begin
      if (bus.load) begin
        disp_d     = bus.bcd_word;
        pend_d     = bus.bcd_word;
        pend_vld_d = 1'b0;
      end else if (pend_vld) begin
        disp_d     = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (bus.load) begin
      pend_d     = bus.bcd_word;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
`ifdef SEG7_LZB_EN
    logic z;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z            = z && (disp_q[4*i +: 4] == 4'd0);
      tail_zero[i] = z;
    end
`endif

    bcd_d = bcd_q;
    en_d  = '0;
    fd_d  = wrap;

    // Code moves only when entering BLANK, so it is settled for SHOW
    if (show_end) begin
      bcd_d = disp_d[4*idx_d +: 4];
    end

    if (state_d == SHOW) begin
      en_d = NUM_DIGITS'(1) << idx_d;
`ifdef SEG7_LZB_EN
      if ((idx_d != '0) && tail_zero[idx_d]) begin
        en_d = '0;
      end
`endif
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.digit_en   = en_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: per-digit expectations are queued per frame.
// Honours SEG7_LZB_EN the same way as the design build.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int P = R + B;
  localparam int F = N * P;

  typedef struct packed {
    logic [N-1:0] en;
    logic [3:0]   bcd;
  } dig_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  dig_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cur_word;
  bit          first;

  task automatic push_frame(input logic [15:0] w);
    for (int d = 0; d < N; d++) begin
      dig_t e;
      bit   z;
      e.bcd = w[4*d +: 4];
      e.en  = N'(1) << d;
      z     = 1'b1;
      for (int k = d; k < N; k++)
        if (w[4*k +: 4] != 4'd0) z = 1'b0;
`ifdef SEG7_LZB_EN
      if (d > 0 && z) e.en = '0;
`endif
      sb.push_back(e);
    end
  endtask

  task automatic run_frame(input int lc1, input logic [15:0] w1,
                           input int lc2, input logic [15:0] w2,
                           input int stop);
    dig_t         e;
    logic [15:0]  nxt;
    logic [N-1:0] exp_en;
    logic         exp_fd;
    nxt = cur_word;
    e   = '0;
    for (int c = 0; c < stop; c++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (c % P == 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty cycle %0d", c);
          e = '0;
        end else begin
          e = sb.pop_front();
        end
      end
      exp_en = (c % P < B) ? '0 : e.en;
      exp_fd = (c == 0) && !first;
      checks += 3;
      if (bus.digit_en !== exp_en) begin
        errors++;
        $display("FAIL digit_en cyc %0d got %b exp %b",
                 c, bus.digit_en, exp_en);
      end
      if (bus.bcd_out !== e.bcd) begin
        errors++;
        $display("FAIL bcd_out cyc %0d got %h exp %h",
                 c, bus.bcd_out, e.bcd);
      end
      if (bus.frame_done !== exp_fd) begin
        errors++;
        $display("FAIL frame_done cyc %0d got %b exp %b",
                 c, bus.frame_done, exp_fd);
      end
      if (c == lc1) begin
        bus.bcd_word = w1;
        bus.load     = 1'b1;
        nxt          = w1;
      end
      if (c == lc2) begin
        bus.bcd_word = w2;
        bus.load     = 1'b1;
        nxt          = w2;
      end
    end
    first = 1'b0;
    if (stop == F) begin
      push_frame(nxt);
      cur_word = nxt;
    end
  endtask

  task automatic restart;
    @(posedge clk);
    #2 rst_n = 1'b1;
    sb.delete();
    cur_word = 16'h0000;
    push_frame(16'h0000);
    first = 1'b1;
  endtask

  task automatic test_reset;
    bus.load     = 1'b0;
    bus.bcd_word = 16'h0000;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks += 3;
    if (bus.digit_en !== 4'b0000) begin
      errors++;
      $display("FAIL rst_digit_en got %b exp 0000", bus.digit_en);
    end
    if (bus.bcd_out !== 4'h0) begin
      errors++;
      $display("FAIL rst_bcd_out got %h exp 0", bus.bcd_out);
    end
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_frame_done got %b exp 0", bus.frame_done);
    end
    restart();
    run_frame(-1, 16'h0, -1, 16'h0, F);
  endtask

  task automatic test_idle;
    run_frame(-1, 16'h0, -1, 16'h0, F);
  endtask

  task automatic test_load_mid;
    run_frame(12, 16'h1234, -1, 16'h0, F);
    run_frame(-1, 16'h0, -1, 16'h0, F);
  endtask

  task automatic test_back_to_back;
    run_frame(5, 16'h1111, 25, 16'h5678, F);
    run_frame(F - 1, 16'h9999, -1, 16'h0, F);
    run_frame(-1, 16'h0, -1, 16'h0, F);
  endtask

  task automatic test_lzb;
    run_frame(3, 16'h0050, -1, 16'h0, F);
    run_frame(3, 16'h0000, -1, 16'h0, F);
    run_frame(-1, 16'h0, -1, 16'h0, F);
  endtask

  task automatic test_non_bcd;
    run_frame(3, 16'h00F0, -1, 16'h0, F);
    run_frame(-1, 16'h0, -1, 16'h0, F);
  endtask

  task automatic test_reset_mid;
    run_frame(3, 16'h8421, -1, 16'h0, F);
    run_frame(-1, 16'h0, -1, 16'h0, 26);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.digit_en !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_digit_en got %b exp 0000", bus.digit_en);
    end
    if (bus.bcd_out !== 4'h0) begin
      errors++;
      $display("FAIL mid_rst_bcd_out got %h exp 0", bus.bcd_out);
    end
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_frame_done got %b exp 0", bus.frame_done);
    end
    if (dut.disp_q !== 16'h0000) begin
      errors++;
      $display("FAIL mid_rst_disp_q got %h exp 0000", dut.disp_q);
    end
    restart();
    run_frame(-1, 16'h0, -1, 16'h0, F);
    run_frame(-1, 16'h0, -1, 16'h0, F);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_mid();
    test_back_to_back();
    test_lzb();
    test_non_bcd();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
